// File: rtl/axis_cfg_sender_pkg.sv
// Shared config-link definitions: FSM states, default frame geometry and index sizing.
package axis_cfg_sender_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_WORDS  = 5;

    // Word index width for a frame of n words (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/axis_cfg_sender.sv
// Streams a captured config image out as an AXI-Stream frame (LSW first) and
// captures status words returned on an independent AXI-Stream slave port.
module axis_cfg_sender
    import axis_cfg_sender_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] cfg_in,
    input  logic                            cfg_load,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           status,
    output logic                            status_valid,
    output logic                            busy,
    output logic                            done,
    output logic [7:0]                      overrun_cnt
);

    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam int unsigned IMG_W = DATA_WIDTH * NUM_WORDS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    cfg_state_e             state_q;
    cfg_state_e             state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [IMG_W-1:0]       shadow_q;
    logic [IMG_W-1:0]       shadow_d;
    logic                   done_d;
    logic                   overrun_inc_c;
    logic                   tx_hs_c;
    logic [DATA_WIDTH-1:0]  word_d;

    assign tx_hs_c = m_axis_tvalid & m_axis_tready;
    assign busy    = (state_q == ST_SEND);
    assign word_d  = shadow_d[32'(idx_d) * DATA_WIDTH +: DATA_WIDTH];

    // Next-state logic: frame start, word advance, back-to-back reload, overrun detection.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        done_d        = 1'b0;
        overrun_inc_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    shadow_d = cfg_in;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_hs_c && (idx_q == LAST_IDX)) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    // A load coinciding with the final handshake chains a new frame.
                    if (cfg_load) begin
                        shadow_d = cfg_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (tx_hs_c) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (cfg_load) begin
                        overrun_inc_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM state, word index and shadow image registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    // Registered master-stream outputs; data only reloads while a frame is active.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            done          <= 1'b0;
        end else begin
            m_axis_tvalid <= (state_d == ST_SEND);
            m_axis_tlast  <= (state_d == ST_SEND) && (idx_d == LAST_IDX);
            done          <= done_d;
            if (state_d == ST_SEND) begin
                m_axis_tdata <= word_d;
            end
        end
    end

    // Saturating count of loads rejected mid-frame.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            overrun_cnt <= '0;
        end else if (overrun_inc_c && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // Status receiver, independent of the transmit FSM; always ready out of reset.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            s_axis_tready <= 1'b0;
            status        <= '0;
            status_valid  <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            status_valid  <= s_axis_tvalid & s_axis_tready;
            if (s_axis_tvalid && s_axis_tready) begin
                status <= s_axis_tdata;
            end
        end
    end

endmodule
